// File: rtl/ccd_window_capture.sv
// Frame-window capture: arms on start, waits for SOF, thresholds the pixels inside a
// runtime-selected (optionally decimated) window into a 1-bit image read back by the detector.
module ccd_window_capture #(
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned PIX_W    = 10,
  parameter int unsigned WIN_W    = 300,
  parameter int unsigned WIN_H    = 150,
  parameter int unsigned DEC_LOG2 = 0,
  localparam int unsigned OUT_W   = WIN_W >> DEC_LOG2,
  localparam int unsigned OUT_H   = WIN_H >> DEC_LOG2,
  localparam int unsigned RA_W    = (OUT_H > 1) ? $clog2(OUT_H) : 1,
  localparam int unsigned CA_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic               pixclk,
  input  logic               RESET_N,
  input  logic               start,
  input  logic [COORD_W-1:0] hsync,
  input  logic [COORD_W-1:0] vsync,
  input  logic               pixvalid,
  input  logic [PIX_W-1:0]   pixvalue,
  input  logic [COORD_W-1:0] win_x0,
  input  logic [COORD_W-1:0] win_y0,
  input  logic [PIX_W-1:0]   threshold,
  input  logic               invert,
  output logic               busy,
  output logic               dataready,
  output logic [7:0]         frame_cnt,
  input  logic [RA_W-1:0]    rd_row,
  input  logic [CA_W-1:0]    rd_col,
  output logic               rd_data
);

  localparam int unsigned Depth = OUT_W * OUT_H;
  localparam int unsigned AW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned LastDxI = ((WIN_W - 1) >> DEC_LOG2) << DEC_LOG2;
  localparam int unsigned LastDyI = ((WIN_H - 1) >> DEC_LOG2) << DEC_LOG2;

  localparam logic [COORD_W:0] WinWLim = (COORD_W + 1)'(WIN_W);
  localparam logic [COORD_W:0] WinHLim = (COORD_W + 1)'(WIN_H);
  localparam logic [COORD_W:0] LastDx  = (COORD_W + 1)'(LastDxI);
  localparam logic [COORD_W:0] LastDy  = (COORD_W + 1)'(LastDyI);
  localparam logic [COORD_W:0] DecMask = (COORD_W + 1)'((1 << DEC_LOG2) - 1);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StWaitSof = 2'd1;
  localparam logic [1:0] StCapture = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
  logic [PIX_W-1:0]   thr_q, thr_d;
  logic               inv_q, inv_d;
  logic               dataready_q, dataready_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               rd_data_q;

  logic               mem_q [Depth];

  logic               sof, in_win, active, accept, last_pix, wr_bit, rd_ok;
  logic [COORD_W:0]   dx, dy, row_idx, col_idx;
  logic [AW-1:0]      wr_addr, rd_addr;

  // Offsets use one extra bit so a pixel left of / above the origin shows as negative.
  assign dx      = {1'b0, hsync} - {1'b0, x0_q};
  assign dy      = {1'b0, vsync} - {1'b0, y0_q};
  assign sof     = pixvalid && (hsync == '0) && (vsync == '0);
  assign in_win  = !dx[COORD_W] && !dy[COORD_W] && (dx < WinWLim) && (dy < WinHLim) &&
                   ((dx & DecMask) == '0) && ((dy & DecMask) == '0);
  // The SOF pixel that starts a capture is itself eligible.
  assign active   = (state_q == StCapture) || ((state_q == StWaitSof) && sof);
  assign accept   = active && pixvalid && in_win;
  assign last_pix = (dx == LastDx) && (dy == LastDy);
  assign wr_bit   = (pixvalue >= thr_q) ^ inv_q;
  assign row_idx  = dy >> DEC_LOG2;
  assign col_idx  = dx >> DEC_LOG2;
  assign wr_addr  = AW'(32'(row_idx) * OUT_W + 32'(col_idx));

  assign rd_ok    = (32'(rd_row) < OUT_H) && (32'(rd_col) < OUT_W);
  assign rd_addr  = AW'(32'(rd_row) * OUT_W + 32'(rd_col));

  always_comb begin
    state_d     = state_q;
    x0_d        = x0_q;
    y0_d        = y0_q;
    thr_d       = thr_q;
    inv_d       = inv_q;
    dataready_d = dataready_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StWaitSof;
          x0_d        = win_x0;
          y0_d        = win_y0;
          thr_d       = threshold;
          inv_d       = invert;
          dataready_d = 1'b0;
        end
      end
      StWaitSof: begin
        if (sof) state_d = StCapture;
      end
      default: ;
    endcase
    if (accept && last_pix) begin
      state_d     = StDone;
      dataready_d = 1'b1;
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge pixclk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      x0_q        <= '0;
      y0_q        <= '0;
      thr_q       <= '0;
      inv_q       <= 1'b0;
      dataready_q <= 1'b0;
      frame_cnt_q <= '0;
      rd_data_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      thr_q       <= thr_d;
      inv_q       <= inv_d;
      dataready_q <= dataready_d;
      frame_cnt_q <= frame_cnt_d;
      rd_data_q   <= rd_ok ? mem_q[rd_addr] : 1'b0;
    end
  end

  // Image memory is deliberately not reset; same-edge read sees the old bit.
  always_ff @(posedge pixclk) begin
    if (accept) mem_q[wr_addr] <= wr_bit;
  end

  assign busy      = (state_q == StWaitSof) || (state_q == StCapture);
  assign dataready = dataready_q;
  assign frame_cnt = frame_cnt_q;
  assign rd_data   = rd_data_q;

endmodule
